// File: rtl/pool_pkg.sv
// pool_pkg: shared reduction FSM states and write-mode encodings
package pool_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} red_state_e;
    localparam logic WR_OVERWRITE = 1'b0;
    localparam logic WR_MAXMERGE  = 1'b1;
endpackage

// File: rtl/pool_max_cmp.sv
// pool_max_cmp: greater-than flag and maximum of two words, signed or unsigned
module pool_max_cmp #(
    parameter int DATA_W     = 16,
    parameter int SIGNED_CMP = 1
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              gt_o,
    output logic [DATA_W-1:0] max_o
);
    assign gt_o  = (SIGNED_CMP != 0) ? ($signed(a_i) > $signed(b_i)) : (a_i > b_i);
    assign max_o = gt_o ? a_i : b_i;
endmodule

// File: rtl/pool_window_regfile.sv
// pool_window_regfile: multi-port register file with max-merge writes and a
// sequential window max-reduction engine
module pool_window_regfile
    import pool_pkg::*;
#(
    parameter int  DATA_W     = 16,
    parameter int  DEPTH      = 16,
    parameter int  WR_PORTS   = 2,
    parameter int  SIGNED_CMP = 1,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               clr,
    input  logic [WR_PORTS-1:0]                wr_en,
    input  logic [WR_PORTS-1:0]                wr_mode,
    input  logic [WR_PORTS-1:0][ADDR_W-1:0]    wr_addr,
    input  logic [WR_PORTS-1:0][DATA_W-1:0]    wr_data,
    input  logic [ADDR_W-1:0]                  rd_addr,
    output logic [DATA_W-1:0]                  rd_data,
    input  logic                               red_start,
    input  logic [ADDR_W-1:0]                  red_base,
    input  logic [ADDR_W:0]                    red_len,
    output logic                               red_busy,
    output logic                               red_valid,
    input  logic                               red_ready,
    output logic [DATA_W-1:0]                  red_max,
    output logic [ADDR_W-1:0]                  red_idx,
    output logic                               red_err
);
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] rd_data_q, best_q, cand, cand_max;
    logic [ADDR_W-1:0] base_q, off_q, bidx_q, cand_addr;
    logic [ADDR_W:0]   len_q;
    logic              err_q, cand_gt, last_off;
    red_state_e        state_q;

    // Each register folds the ports in ascending order so later ports see earlier results
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        for (genvar p = 0; p < WR_PORTS; p++) begin : g_port
            logic [DATA_W-1:0] prev, mx, nxt;
            logic              gt_unused;
            if (p == 0) begin : g_first
                assign prev = regs_q[r];
            end else begin : g_chain
                assign prev = g_port[p-1].nxt;
            end
            pool_max_cmp #(.DATA_W(DATA_W), .SIGNED_CMP(SIGNED_CMP)) u_cmp (
                .a_i(wr_data[p]), .b_i(prev), .gt_o(gt_unused), .max_o(mx)
            );
            assign nxt = (wr_en[p] && wr_addr[p] == ADDR_W'(r))
                       ? (wr_mode[p] == WR_MAXMERGE ? mx : wr_data[p]) : prev;
        end
        assign regs_d[r] = g_port[WR_PORTS-1].nxt;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            rd_data_q <= '0;
        end else begin
            rd_data_q <= regs_q[rd_addr];
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= clr ? '0 : regs_d[i];
        end
    end

    // Offsets wrap naturally in ADDR_W bits, giving the mod-DEPTH window
    assign cand_addr = base_q + off_q;
    assign cand      = regs_q[cand_addr];
    assign last_off  = {1'b0, off_q} == len_q - (ADDR_W+1)'(1);

    pool_max_cmp #(.DATA_W(DATA_W), .SIGNED_CMP(SIGNED_CMP)) u_red_cmp (
        .a_i(cand), .b_i(best_q), .gt_o(cand_gt), .max_o(cand_max)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            base_q  <= '0;
            off_q   <= '0;
            len_q   <= '0;
            best_q  <= '0;
            bidx_q  <= '0;
            err_q   <= 1'b0;
        end else if (clr) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (red_start) begin
                    base_q  <= red_base;
                    len_q   <= red_len;
                    off_q   <= ADDR_W'(1);
                    bidx_q  <= red_base;
                    err_q   <= red_len == '0;
                    best_q  <= (red_len == '0) ? '0 : regs_q[red_base];
                    state_q <= (red_len > (ADDR_W+1)'(1)) ? SCAN : DONE;
                end
                SCAN: begin
                    best_q  <= cand_max;
                    bidx_q  <= cand_gt ? cand_addr : bidx_q;
                    off_q   <= off_q + ADDR_W'(1);
                    state_q <= last_off ? DONE : SCAN;
                end
                DONE:    state_q <= red_ready ? IDLE : DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data   = rd_data_q;
    assign red_busy  = state_q != IDLE;
    assign red_valid = state_q == DONE;
    assign red_max   = best_q;
    assign red_idx   = bidx_q;
    assign red_err   = err_q;
endmodule

// File: tb/tb_pool_window_regfile.sv
// tb_pool_window_regfile: scoreboard bench driving a signed and an unsigned
// instance with shared stimulus
module tb_pool_window_regfile;
    localparam int DW = 16, D = 16, WP = 2, AW = 4;

    logic clk = 1'b0, nrst = 1'b0, clr;
    logic [WP-1:0] wr_en, wr_mode;
    logic [WP-1:0][AW-1:0] wr_addr;
    logic [WP-1:0][DW-1:0] wr_data;
    logic [AW-1:0] rd_addr, red_base;
    logic [AW:0]   red_len;
    logic          red_start, red_ready;
    logic [DW-1:0] rd_data_s, rd_data_u, red_max_s, red_max_u;
    logic [AW-1:0] red_idx_s, red_idx_u;
    logic          red_busy_s, red_busy_u, red_valid_s, red_valid_u, red_err_s, red_err_u;

    typedef struct packed {logic [DW-1:0] mx; logic [AW-1:0] idx; logic err;} red_t;
    red_t          rq_s[$], rq_u[$];
    logic [DW-1:0] rdq_s[$], rdq_u[$];
    logic [DW-1:0] m_s[D], m_u[D];
    int            n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    pool_window_regfile #(.DATA_W(DW), .DEPTH(D), .WR_PORTS(WP), .SIGNED_CMP(1)) u_dut_s (
        .clk(clk), .nrst(nrst), .clr(clr), .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_s), .red_start(red_start),
        .red_base(red_base), .red_len(red_len), .red_busy(red_busy_s), .red_valid(red_valid_s),
        .red_ready(red_ready), .red_max(red_max_s), .red_idx(red_idx_s), .red_err(red_err_s)
    );

    pool_window_regfile #(.DATA_W(DW), .DEPTH(D), .WR_PORTS(WP), .SIGNED_CMP(0)) u_dut_u (
        .clk(clk), .nrst(nrst), .clr(clr), .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_u), .red_start(red_start),
        .red_base(red_base), .red_len(red_len), .red_busy(red_busy_u), .red_valid(red_valid_u),
        .red_ready(red_ready), .red_max(red_max_u), .red_idx(red_idx_u), .red_err(red_err_u)
    );

    function automatic logic gt_m(input bit sgn, input logic [DW-1:0] a, input logic [DW-1:0] b);
        return sgn ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    function automatic red_t exp_red(input bit sgn, input logic [AW-1:0] base, input logic [AW:0] len);
        red_t r;
        logic [AW-1:0] a;
        r.mx  = '0;
        r.idx = base;
        r.err = (len == '0);
        if (len != '0) begin
            r.mx = sgn ? m_s[base] : m_u[base];
            for (int o = 1; o < int'(len); o++) begin
                a = base + AW'(o);
                if (gt_m(sgn, sgn ? m_s[a] : m_u[a], r.mx)) begin
                    r.mx  = sgn ? m_s[a] : m_u[a];
                    r.idx = a;
                end
            end
        end
        return r;
    endfunction

    task automatic clear_models();
        for (int i = 0; i < D; i++) begin
            m_s[i] = '0;
            m_u[i] = '0;
        end
    endtask

    // Applies the current inputs to the reference models, then advances one clock
    task automatic step();
        if (!nrst || clr) clear_models();
        else for (int p = 0; p < WP; p++) if (wr_en[p]) begin
            if (!wr_mode[p] || gt_m(1, wr_data[p], m_s[wr_addr[p]])) m_s[wr_addr[p]] = wr_data[p];
            if (!wr_mode[p] || gt_m(0, wr_data[p], m_u[wr_addr[p]])) m_u[wr_addr[p]] = wr_data[p];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 1'b0; wr_en = '0; wr_mode = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        red_start = 1'b0; red_ready = 1'b0; red_base = '0; red_len = '0;
    endtask

    task automatic wr(input int p, input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p] = 1'b1; wr_mode[p] = mode; wr_addr[p] = a; wr_data[p] = d;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        clear_models();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({rd_data_s, red_busy_s, red_valid_s, red_max_s, red_idx_s, red_err_s} !== '0) begin
            n_err++;
            $display("FAIL reset_s got rd=%h busy=%b valid=%b max=%h idx=%h err=%b want all zero",
                     rd_data_s, red_busy_s, red_valid_s, red_max_s, red_idx_s, red_err_s);
        end
        n_vec++;
        if ({rd_data_u, red_busy_u, red_valid_u, red_max_u, red_idx_u, red_err_u} !== '0) begin
            n_err++;
            $display("FAIL reset_u got rd=%h busy=%b valid=%b max=%h idx=%h err=%b want all zero",
                     rd_data_u, red_busy_u, red_valid_u, red_max_u, red_idx_u, red_err_u);
        end
        nrst = 1'b1;
        step();
    endtask

    task automatic test_overwrite();
        logic [DW-1:0] es, eu;
        wr(0, 1'b0, 4'd3, 16'h0010);
        wr(1, 1'b0, 4'd3, 16'h0020);
        step();
        wr_en = '0;
        // second read shares the cycle with a write to the same address
        for (int i = 0; i < 3; i++) begin
            rd_addr = 4'd3;
            if (i == 1) wr(0, 1'b0, 4'd3, 16'h0055);
            else wr_en = '0;
            rdq_s.push_back(m_s[rd_addr]);
            step();
            es = rdq_s.pop_front();
            n_vec++;
            if (rd_data_s !== es) begin
                n_err++;
                $display("FAIL overwrite_rd%0d got %h want %h", i, rd_data_s, es);
            end
        end
        wr_en = '0;
        for (int i = 0; i < 24; i++) begin
            wr_en = WP'($urandom);
            wr_mode = WP'($urandom);
            for (int p = 0; p < WP; p++) begin
                wr_addr[p] = AW'($urandom_range(0, 3));
                wr_data[p] = DW'($urandom);
            end
            rd_addr = AW'($urandom_range(0, 3));
            rdq_s.push_back(m_s[rd_addr]);
            rdq_u.push_back(m_u[rd_addr]);
            step();
            es = rdq_s.pop_front();
            eu = rdq_u.pop_front();
            n_vec++;
            if (rd_data_s !== es) begin
                n_err++;
                $display("FAIL rand_rd_s iter %0d got %h want %h", i, rd_data_s, es);
            end
            n_vec++;
            if (rd_data_u !== eu) begin
                n_err++;
                $display("FAIL rand_rd_u iter %0d got %h want %h", i, rd_data_u, eu);
            end
        end
        wr_en = '0;
    endtask

    task automatic test_merge();
        logic [DW-1:0] es, eu;
        wr(0, 1'b0, 4'd5, 16'h0005);
        step();
        wr(0, 1'b1, 4'd5, 16'hFFFF);
        wr(1, 1'b1, 4'd5, 16'h0003);
        step();
        wr_en = '0;
        rd_addr = 4'd5;
        rdq_s.push_back(m_s[5]);
        rdq_u.push_back(m_u[5]);
        step();
        es = rdq_s.pop_front();
        eu = rdq_u.pop_front();
        n_vec++;
        if (rd_data_s !== es) begin
            n_err++;
            $display("FAIL merge_signed got %h want %h", rd_data_s, es);
        end
        n_vec++;
        if (rd_data_u !== eu) begin
            n_err++;
            $display("FAIL merge_unsigned got %h want %h", rd_data_u, eu);
        end
    endtask

    task automatic test_reduce();
        int   bases[5] = '{14, 3, 9, 0, 7};
        int   lens[5]  = '{4, 1, 16, 16, 2};
        int   n, lat;
        red_t e;
        wr(0, 1'b0, 4'd14, 16'd7);
        wr(1, 1'b0, 4'd15, 16'd9);
        step();
        wr(0, 1'b0, 4'd0, 16'd9);
        wr(1, 1'b0, 4'd1, 16'd2);
        step();
        for (int k = 0; k < 5; k++) begin
            if (k == 1) for (int i = 0; i < 8; i++) begin
                wr(0, 1'b0, AW'(2 * i), DW'($urandom));
                wr(1, 1'b0, AW'(2 * i + 1), DW'($urandom));
                step();
            end
            wr_en = '0;
            red_base = AW'(bases[k]);
            red_len = (AW+1)'(lens[k]);
            red_start = 1'b1;
            rq_s.push_back(exp_red(1, red_base, red_len));
            rq_u.push_back(exp_red(0, red_base, red_len));
            lat = lens[k] > 1 ? lens[k] : 1;
            n = 0;
            do begin
                step();
                red_start = 1'b0;
                n++;
                if (n == 1 && lat > 1) begin
                    n_vec++;
                    if (red_busy_s !== 1'b1 || red_valid_s !== 1'b0) begin
                        n_err++;
                        $display("FAIL red_scan case %0d got busy=%b valid=%b want busy=1 valid=0",
                                 k, red_busy_s, red_valid_s);
                    end
                end
            end while (!red_valid_s && n < 40);
            n_vec++;
            if (n != lat) begin
                n_err++;
                $display("FAIL red_latency case %0d got %0d want %0d", k, n, lat);
            end
            e = rq_s.pop_front();
            n_vec++;
            if ({red_max_s, red_idx_s, red_err_s} !== e) begin
                n_err++;
                $display("FAIL red_result_s case %0d got max=%h idx=%0d err=%b want max=%h idx=%0d err=%b",
                         k, red_max_s, red_idx_s, red_err_s, e.mx, e.idx, e.err);
            end
            e = rq_u.pop_front();
            n_vec++;
            if ({red_valid_u, red_max_u, red_idx_u, red_err_u} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL red_result_u case %0d got v=%b max=%h idx=%0d err=%b want v=1 max=%h idx=%0d err=%b",
                         k, red_valid_u, red_max_u, red_idx_u, red_err_u, e.mx, e.idx, e.err);
            end
            red_ready = 1'b1;
            step();
            red_ready = 1'b0;
            n_vec++;
            if (red_valid_s !== 1'b0 || red_busy_s !== 1'b0) begin
                n_err++;
                $display("FAIL red_release case %0d got valid=%b busy=%b want 0 0", k, red_valid_s, red_busy_s);
            end
        end
    endtask

    task automatic test_len0();
        red_t e;
        red_base = 4'd6;
        red_len = '0;
        red_start = 1'b1;
        rq_s.push_back(exp_red(1, red_base, red_len));
        step();
        red_base = 4'd2;
        red_len = 5'd3;
        e = rq_s.pop_front();
        n_vec++;
        if ({red_valid_s, red_max_s, red_idx_s, red_err_s} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL len0_first got v=%b max=%h idx=%0d err=%b want v=1 max=%h idx=%0d err=%b",
                     red_valid_s, red_max_s, red_idx_s, red_err_s, e.mx, e.idx, e.err);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if ({red_valid_s, red_busy_s, red_max_s, red_idx_s, red_err_s} !== {2'b11, e}) begin
                n_err++;
                $display("FAIL len0_hold cycle %0d got v=%b b=%b max=%h idx=%0d err=%b want v=1 b=1 max=%h idx=%0d err=%b",
                         i, red_valid_s, red_busy_s, red_max_s, red_idx_s, red_err_s, e.mx, e.idx, e.err);
            end
        end
        red_ready = 1'b1;
        step();
        red_ready = 1'b0;
        red_start = 1'b0;
        n_vec++;
        if (red_valid_s !== 1'b0 || red_busy_s !== 1'b0) begin
            n_err++;
            $display("FAIL len0_handoff got valid=%b busy=%b want 0 0", red_valid_s, red_busy_s);
        end
        step();
        n_vec++;
        if (red_busy_s !== 1'b0) begin
            n_err++;
            $display("FAIL handoff_start_ignored got busy=%b want 0", red_busy_s);
        end
    endtask

    task automatic test_clr();
        logic [DW-1:0] es;
        red_t e;
        int seen;
        red_base = '0;
        red_len = 5'd16;
        red_start = 1'b1;
        step();
        red_start = 1'b0;
        repeat (2) step();
        clr = 1'b1;
        wr(0, 1'b0, 4'd4, 16'h1234);
        step();
        clr = 1'b0;
        wr_en = '0;
        n_vec++;
        if (red_busy_s !== 1'b0 || red_valid_s !== 1'b0) begin
            n_err++;
            $display("FAIL clr_abort got busy=%b valid=%b want 0 0", red_busy_s, red_valid_s);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (red_valid_s !== 1'b0) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL clr_no_valid got %0d valid cycles want 0", seen);
        end
        for (int a = 0; a < D; a++) begin
            rd_addr = AW'(a);
            rdq_s.push_back(m_s[a]);
            step();
            es = rdq_s.pop_front();
            n_vec++;
            if (rd_data_s !== es) begin
                n_err++;
                $display("FAIL clr_reg%0d got %h want %h", a, rd_data_s, es);
            end
        end
        wr(0, 1'b0, 4'd2, 16'h0042);
        step();
        wr_en = '0;
        rd_addr = 4'd2;
        red_base = 4'd2;
        red_len = 5'd1;
        red_start = 1'b1;
        rq_s.push_back(exp_red(1, red_base, red_len));
        step();
        red_start = 1'b0;
        e = rq_s.pop_front();
        n_vec++;
        if ({red_valid_s, red_max_s, red_idx_s, red_err_s} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL len1_done got v=%b max=%h idx=%0d err=%b want v=1 max=%h idx=%0d err=%b",
                     red_valid_s, red_max_s, red_idx_s, red_err_s, e.mx, e.idx, e.err);
        end
        #1 nrst = 1'b0;
        #1;
        n_vec++;
        if ({rd_data_s, red_busy_s, red_valid_s, red_max_s, red_idx_s, red_err_s} !== '0) begin
            n_err++;
            $display("FAIL async_reset got rd=%h busy=%b valid=%b max=%h idx=%h err=%b want all zero",
                     rd_data_s, red_busy_s, red_valid_s, red_max_s, red_idx_s, red_err_s);
        end
        #2 nrst = 1'b1;
        clear_models();
        step();
        rdq_s.push_back(m_s[2]);
        step();
        es = rdq_s.pop_front();
        n_vec++;
        if (rd_data_s !== es) begin
            n_err++;
            $display("FAIL reset_reg2 got %h want %h", rd_data_s, es);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_overwrite();
        test_merge();
        test_reduce();
        test_len0();
        test_clr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
